// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front-end pipeline: instruction encodings,
// fetch increment, default control width and the stall watchdog state type.
package cpu_pkg;

   // Canonical NOP written into IF/ID when the latch is cleared
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Sequential fetch advances by one 32-bit instruction word
   localparam logic [31:0] PC_INC = 32'd4;

   // Default width of the decoded control bundle carried into ID/EX
   localparam int CTRL_W_DEFAULT = 10;

   // Stall watchdog states: normal flow, inside a stall run, hung (sticky)
   typedef enum logic [1:0] {
      WD_RUN   = 2'd0,
      WD_STALL = 2'd1,
      WD_HUNG  = 2'd2
   } wd_state_e;

endpackage : cpu_pkg

// File: rtl/stall_watchdog.sv
// Stall watchdog: measures the length of the current run of consecutive
// stall cycles and raises a sticky flag once the run exceeds MAX_STALL.
// Only a reset clears the flag; it never influences the pipeline itself.
module stall_watchdog
   import cpu_pkg::*;
#(
   parameter int MAX_STALL = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic stall_cycle,
   output logic stall_timeout
);

   // Wide enough to hold MAX_STALL+1, the run length that trips HUNG
   localparam int RUN_W = $clog2(MAX_STALL + 2);

   wd_state_e        state_q;
   logic [RUN_W-1:0] run_len_q;
   logic             stall_timeout_q;

   // Watchdog FSM with run counter and registered timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= WD_RUN;
         run_len_q       <= '0;
         stall_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            WD_RUN: begin
               if (stall_cycle) begin
                  state_q   <= WD_STALL;
                  run_len_q <= RUN_W'(1);
               end
            end
            WD_STALL: begin
               if (stall_cycle) begin
                  run_len_q <= run_len_q + RUN_W'(1);
                  // The run that just got one cycle longer is too long
                  if ((int'(run_len_q) + 1) > MAX_STALL) begin
                     state_q         <= WD_HUNG;
                     stall_timeout_q <= 1'b1;
                  end
               end else begin
                  state_q   <= WD_RUN;
                  run_len_q <= '0;
               end
            end
            WD_HUNG: begin
               // Terminal: only rst leaves this state
               stall_timeout_q <= 1'b1;
            end
            default: begin
               state_q   <= WD_RUN;
               run_len_q <= '0;
            end
         endcase
      end
   end

   assign stall_timeout = stall_timeout_q;

endmodule : stall_watchdog

// File: rtl/if_id_pipeline.sv
// Front-end pipeline registers: PC, IF/ID latch and the control half of the
// ID/EX latch. Applies hazard-unit stall/flush requests and EX-stage branch
// redirects, keeps saturating stall/flush statistics and hosts the stall
// watchdog.
module if_id_pipeline
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          CTRL_W    = CTRL_W_DEFAULT,
   parameter int          CNT_W     = 16,
   parameter int          MAX_STALL = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              PCWrite,
   input  logic              IFIDWrite,
   input  logic              IDFlush,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   input  logic [31:0]       instr_if,
   input  logic [CTRL_W-1:0] ctrl_id,
   output logic [31:0]       pc,
   output logic [31:0]       instr_id,
   output logic [31:0]       pc4_id,
   output logic              valid_id,
   output logic [CTRL_W-1:0] ctrl_ex,
   output logic              valid_ex,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic              stall_timeout
);

   logic [31:0]       pc_q,       pc_d;
   logic [31:0]       instr_id_q, instr_id_d;
   logic [31:0]       pc4_id_q,   pc4_id_d;
   logic              valid_id_q, valid_id_d;
   logic [CTRL_W-1:0] ctrl_ex_q,  ctrl_ex_d;
   logic              valid_ex_q, valid_ex_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic [31:0] pc_plus4;
   logic        stall_cycle;

   // Next-state for PC, IF/ID, ID/EX control and statistics counters
   always_comb begin
      // Wraps naturally modulo 2^32
      pc_plus4 = pc_q + PC_INC;

      // A redirect overrides any stall request in the same cycle
      stall_cycle = PCWrite & IFIDWrite & ~branch_taken;

      // PC: redirect, else hold on PCWrite, else sequential
      if (branch_taken) begin
         pc_d = branch_target;
      end else if (PCWrite) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_plus4;
      end

      // IF/ID: kill the fetched instruction on redirect, hold on IFIDWrite
      if (branch_taken) begin
         instr_id_d = NOP_INSTR;
         pc4_id_d   = 32'h0000_0000;
         valid_id_d = 1'b0;
      end else if (IFIDWrite) begin
         instr_id_d = instr_id_q;
         pc4_id_d   = pc4_id_q;
         valid_id_d = valid_id_q;
      end else begin
         instr_id_d = instr_if;
         pc4_id_d   = pc_plus4;
         valid_id_d = 1'b1;
      end

      // ID/EX control: bubble on hazard flush or on redirect of the ID slot
      if (IDFlush || branch_taken) begin
         ctrl_ex_d  = '0;
         valid_ex_d = 1'b0;
      end else begin
         ctrl_ex_d  = ctrl_id;
         valid_ex_d = valid_id_q;
      end

      // Statistics saturate at all-ones rather than wrapping
      stall_cnt_d = stall_cnt_q;
      if (stall_cycle && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end

      flush_cnt_d = flush_cnt_q;
      if (branch_taken && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // Pipeline and statistics registers, cleared immediately by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         instr_id_q  <= NOP_INSTR;
         pc4_id_q    <= 32'h0000_0000;
         valid_id_q  <= 1'b0;
         ctrl_ex_q   <= '0;
         valid_ex_q  <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         instr_id_q  <= instr_id_d;
         pc4_id_q    <= pc4_id_d;
         valid_id_q  <= valid_id_d;
         ctrl_ex_q   <= ctrl_ex_d;
         valid_ex_q  <= valid_ex_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   stall_watchdog #(
      .MAX_STALL (MAX_STALL)
   ) u_stall_watchdog (
      .clk           (clk),
      .rst           (rst),
      .stall_cycle   (stall_cycle),
      .stall_timeout (stall_timeout)
   );

   assign pc        = pc_q;
   assign instr_id  = instr_id_q;
   assign pc4_id    = pc4_id_q;
   assign valid_id  = valid_id_q;
   assign ctrl_ex   = ctrl_ex_q;
   assign valid_ex  = valid_ex_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule : if_id_pipeline
